// File: rtl/cpu_nibble_mem_pkg.sv
// Shared types and constants for the nibble program/data store.
package cpu_nibble_mem_pkg;

    // Default geometry of the CPU bus and the store behind it.
    localparam int DEFAULT_ADDR_W = 7;
    localparam int DEFAULT_DATA_W = 4;

    // Field positions inside the 8-bit CPU bus word.
    localparam int WCYC_BIT = 7;
    localparam int ADDR_MSB = 6;
    localparam int DATA_MSB = 3;

    // Control states: CPU fetch/load, store data phase, host programming,
    // and the single cycle that keeps the CPU in reset after programming.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WDATA   = 2'd1,
        PROG    = 2'd2,
        RELEASE = 2'd3
    } state_t;

endpackage

// File: rtl/nibble_mem_array.sv
// DEPTH x DATA_W flop array: one synchronous write port, one asynchronous
// read port, synchronous clear of every entry.
module nibble_mem_array #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Clear all entries on reset, otherwise take one write per cycle.
    // NOTE: clearing the whole array on reset forces it into flops (no RAM
    // macro can do this); that is intended, the CPU expects zeros after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_nibble_mem.sv
// Program/data store for the 4-bit accumulator CPU: decodes the CPU bus,
// returns nibbles combinationally, captures two-phase stores, and lets a
// host stream in a program while the CPU is held in reset.
module cpu_nibble_mem
    import cpu_nibble_mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        bus_in,
    output logic [DATA_W-1:0] data_out,
    output logic              cpu_rst,
    input  logic              prog_en,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic [ADDR_W-1:0] prog_ptr,
    output logic              wr_strobe
);

    state_t            state;
    logic [ADDR_W-1:0] waddr;

    logic              wcyc;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_data;

    logic              host_we;
    logic              cpu_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_data;

    assign wcyc     = bus_in[WCYC_BIT];
    assign bus_addr = bus_in[ADDR_MSB:0];
    assign bus_data = bus_in[DATA_MSB:0];

    // A host nibble lands whenever we are programming; a CPU store lands
    // only if its data phase is not pre-empted by a programming request.
    assign host_we = (state == PROG) && prog_valid;
    assign cpu_we  = (state == WDATA) && wcyc && !prog_en;
    assign mem_we  = host_we || cpu_we;

    // Steer the single write port to whichever side owns it this cycle.
    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        mem_waddr = prog_ptr;
        mem_wdata = prog_data;
        if (cpu_we) begin
            mem_waddr = waddr;
            mem_wdata = bus_data;
        end
    end

    nibble_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (bus_addr),
        .rdata (rd_data)
    );

    // Control FSM plus the store address latch, host pointer and strobe.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; the later prog_ptr clear intentionally
    // overrides the increment in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            waddr     <= '0;
            prog_ptr  <= '0;
            wr_strobe <= 1'b0;
        end else begin
            wr_strobe <= cpu_we;
            unique case (state)
                IDLE: begin
                    if (prog_en) begin
                        state <= PROG;
                    end else if (wcyc) begin
                        waddr <= bus_addr;
                        state <= WDATA;
                    end
                end
                WDATA: begin
                    // Commit or abort, the data phase always ends here.
                    state <= prog_en ? PROG : IDLE;
                end
                PROG: begin
                    if (prog_valid) begin
                        prog_ptr <= (prog_ptr == ADDR_W'(DEPTH - 1)) ? '0 : prog_ptr + 1'b1;
                    end
                    if (!prog_en) begin
                        prog_ptr <= '0;
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    state <= prog_en ? PROG : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The CPU is held in reset during block reset, programming and the
    // release cycle, so its first fetch happens in the first IDLE cycle.
    assign cpu_rst    = !rst_n || (state == PROG) || (state == RELEASE);
    assign prog_ready = rst_n && (state == PROG);
    assign data_out   = (rst_n && (state == IDLE) && !wcyc) ? rd_data : '0;

endmodule

// File: tb/tb_cpu_nibble_mem.sv
// Directed bench for cpu_nibble_mem: a table of per-cycle vectors followed
// by hand-written sequences for pointer wrap and reset during a store.
module tb_cpu_nibble_mem;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bus_in;
    logic [3:0] data_out;
    logic       cpu_rst;
    logic       prog_en;
    logic       prog_valid;
    logic [3:0] prog_data;
    logic       prog_ready;
    logic [6:0] prog_ptr;
    logic       wr_strobe;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_nibble_mem dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_in     (bus_in),
        .data_out   (data_out),
        .cpu_rst    (cpu_rst),
        .prog_en    (prog_en),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .prog_ptr   (prog_ptr),
        .wr_strobe  (wr_strobe)
    );

    typedef struct {
        string      name;
        logic       rst_n;
        logic       prog_en;
        logic       prog_valid;
        logic [3:0] prog_data;
        logic [7:0] bus;
        bit         chk_data;
        logic [3:0] data;
        logic       cpu_rst;
        logic       ready;
        logic [6:0] ptr;
        logic       strobe;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void add(input string n, input logic r, input logic pe, input logic pv,
                                input logic [3:0] pd, input logic [7:0] b, input bit cd,
                                input logic [3:0] d, input logic cr, input logic rdy,
                                input logic [6:0] p, input logic s);
        vecs.push_back('{n, r, pe, pv, pd, b, cd, d, cr, rdy, p, s});
    endfunction

    task automatic drive(input logic r, input logic pe, input logic pv,
                         input logic [3:0] pd, input logic [7:0] b);
        rst_n      = r;
        prog_en    = pe;
        prog_valid = pv;
        prog_data  = pd;
        bus_in     = b;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] wrap_val(input int k);
        if (k == 128) return 4'hE;
        if (k == 129) return 4'hD;
        return k[3:0];
    endfunction

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //   name             rst pe pv pd    bus    cd  data cpu_rst rdy ptr   strobe
        add("reset",          0, 0, 0, 4'h0, 8'h00, 1, 4'h0, 1, 0, 7'd0, 0);
        add("idle_pe_req",    1, 1, 0, 4'h0, 8'h00, 1, 4'h0, 0, 0, 7'd0, 0);
        add("prog_w9",        1, 1, 1, 4'h9, 8'h00, 1, 4'h0, 1, 1, 7'd0, 0);
        add("prog_w0",        1, 1, 1, 4'h0, 8'h00, 1, 4'h0, 1, 1, 7'd1, 0);
        add("prog_w3",        1, 1, 1, 4'h3, 8'h00, 1, 4'h0, 1, 1, 7'd2, 0);
        add("prog_hold",      1, 1, 0, 4'h0, 8'h00, 1, 4'h0, 1, 1, 7'd3, 0);
        add("prog_drop",      1, 0, 0, 4'h0, 8'h00, 1, 4'h0, 1, 1, 7'd3, 0);
        add("release",        1, 0, 0, 4'h0, 8'h00, 1, 4'h0, 1, 0, 7'd0, 0);
        add("rd_00",          1, 0, 0, 4'h0, 8'h00, 1, 4'h9, 0, 0, 7'd0, 0);
        add("rd_01",          1, 0, 0, 4'h0, 8'h01, 1, 4'h0, 0, 0, 7'd0, 0);
        add("rd_02",          1, 0, 0, 4'h0, 8'h02, 1, 4'h3, 0, 0, 7'd0, 0);
        add("rd_05",          1, 0, 0, 4'h0, 8'h05, 1, 4'h0, 0, 0, 7'd0, 0);
        add("rd_7f",          1, 0, 0, 4'h0, 8'h7F, 1, 4'h0, 0, 0, 7'd0, 0);
        add("pv_ign_idle",    1, 0, 1, 4'hF, 8'h03, 1, 4'h0, 0, 0, 7'd0, 0);
        add("st_addr_2a",     1, 0, 0, 4'h0, 8'hAA, 0, 4'h0, 0, 0, 7'd0, 0);
        add("st_data_7",      1, 0, 0, 4'h0, 8'h87, 1, 4'h0, 0, 0, 7'd0, 0);
        add("rd_2a_strobe",   1, 0, 0, 4'h0, 8'h2A, 1, 4'h7, 0, 0, 7'd0, 1);
        add("rd_2a_again",    1, 0, 0, 4'h0, 8'h2A, 1, 4'h7, 0, 0, 7'd0, 0);
        add("ab_addr_15",     1, 0, 0, 4'h0, 8'h95, 0, 4'h0, 0, 0, 7'd0, 0);
        add("ab_nodata",      1, 0, 0, 4'h0, 8'h13, 1, 4'h0, 0, 0, 7'd0, 0);
        add("ab_rd_15",       1, 0, 0, 4'h0, 8'h15, 1, 4'h0, 0, 0, 7'd0, 0);
        add("b2b_addr_5",     1, 0, 0, 4'h0, 8'h85, 0, 4'h0, 0, 0, 7'd0, 0);
        add("b2b_data_c",     1, 0, 0, 4'h0, 8'h8C, 1, 4'h0, 0, 0, 7'd0, 0);
        add("b2b_addr_6",     1, 0, 0, 4'h0, 8'h86, 0, 4'h0, 0, 0, 7'd0, 1);
        add("b2b_data_1",     1, 0, 0, 4'h0, 8'h81, 1, 4'h0, 0, 0, 7'd0, 0);
        add("b2b_rd_5",       1, 0, 0, 4'h0, 8'h05, 1, 4'hC, 0, 0, 7'd0, 1);
        add("b2b_rd_6",       1, 0, 0, 4'h0, 8'h06, 1, 4'h1, 0, 0, 7'd0, 0);
        add("pw_addr_8",      1, 0, 0, 4'h0, 8'h88, 0, 4'h0, 0, 0, 7'd0, 0);
        add("pw_preempt",     1, 1, 0, 4'h0, 8'h8F, 1, 4'h0, 0, 0, 7'd0, 0);
        add("pw_prog",        1, 0, 0, 4'h0, 8'h8F, 1, 4'h0, 1, 1, 7'd0, 0);
        add("pw_release",     1, 0, 0, 4'h0, 8'h08, 1, 4'h0, 1, 0, 7'd0, 0);
        add("pw_rd_8",        1, 0, 0, 4'h0, 8'h08, 1, 4'h0, 0, 0, 7'd0, 0);
        add("pa_addr_pe",     1, 1, 0, 4'h0, 8'h89, 0, 4'h0, 0, 0, 7'd0, 0);
        add("pa_prog",        1, 0, 0, 4'h0, 8'h8F, 1, 4'h0, 1, 1, 7'd0, 0);
        add("pa_release",     1, 0, 0, 4'h0, 8'h09, 1, 4'h0, 1, 0, 7'd0, 0);
        add("pa_rd_9",        1, 0, 0, 4'h0, 8'h09, 1, 4'h0, 0, 0, 7'd0, 0);

        drive(0, 0, 0, 4'h0, 8'h00);
        step();
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].prog_en, vecs[i].prog_valid, vecs[i].prog_data, vecs[i].bus);
            if (vecs[i].chk_data) check({vecs[i].name, ".data_out"}, 32'(data_out), 32'(vecs[i].data));
            check({vecs[i].name, ".cpu_rst"},    32'(cpu_rst),    32'(vecs[i].cpu_rst));
            check({vecs[i].name, ".prog_ready"}, 32'(prog_ready), 32'(vecs[i].ready));
            check({vecs[i].name, ".prog_ptr"},   32'(prog_ptr),   32'(vecs[i].ptr));
            check({vecs[i].name, ".wr_strobe"},  32'(wr_strobe),  32'(vecs[i].strobe));
            step();
        end

        // Host streams 130 nibbles: the pointer wraps and overwrites 0 and 1.
        drive(1, 1, 0, 4'h0, 8'h00);
        step();
        for (int k = 0; k < 130; k++) begin
            drive(1, 1, 1, wrap_val(k), 8'h00);
            check($sformatf("wrap_ptr_%0d", k), 32'(prog_ptr), 32'(k % 128));
            step();
        end
        drive(1, 1, 0, 4'h0, 8'h00);
        check("wrap_ptr_end", 32'(prog_ptr), 32'd2);
        check("wrap_ready", 32'(prog_ready), 32'd1);
        drive(1, 0, 0, 4'h0, 8'h00);
        step();
        check("wrap_rel_ptr", 32'(prog_ptr), 32'd0);
        check("wrap_rel_cpu_rst", 32'(cpu_rst), 32'd1);
        step();
        check("wrap_idle_cpu_rst", 32'(cpu_rst), 32'd0);
        check("wrap_rd_00", 32'(data_out), 32'hE);
        drive(1, 0, 0, 4'h0, 8'h01);
        check("wrap_rd_01", 32'(data_out), 32'hD);
        drive(1, 0, 0, 4'h0, 8'h02);
        check("wrap_rd_02", 32'(data_out), 32'h2);
        drive(1, 0, 0, 4'h0, 8'h2A);
        check("wrap_rd_2a", 32'(data_out), 32'hA);
        drive(1, 0, 0, 4'h0, 8'h7F);
        check("wrap_rd_7f", 32'(data_out), 32'hF);
        step();

        // Reset between the address and data phases of a store.
        drive(1, 0, 0, 4'h0, 8'h83);
        step();
        drive(0, 0, 0, 4'h0, 8'h85);
        check("rst_mid_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_mid_data", 32'(data_out), 32'd0);
        check("rst_mid_ready", 32'(prog_ready), 32'd0);
        step();
        drive(1, 0, 0, 4'h0, 8'h00);
        check("rst_after_strobe", 32'(wr_strobe), 32'd0);
        check("rst_after_cpu_rst", 32'(cpu_rst), 32'd0);
        check("rst_after_ptr", 32'(prog_ptr), 32'd0);
        for (int a = 0; a < 128; a++) begin
            drive(1, 0, 0, 4'h0, 8'(a));
            check($sformatf("rst_clear_%0h", a), 32'(data_out), 32'd0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_nibble_mem.md
# cpu_nibble_mem

Program/data store that sits directly downstream of the 4-bit accumulator CPU's 8-bit bus output and feeds its 4-bit data input. It decodes the CPU's bus (7-bit address plus write-cycle flag), returns the addressed nibble combinationally for fetches and loads, and captures the CPU's two-cycle store sequence (address phase, then data phase). A host-side streaming port preloads a program while the block holds the CPU in reset.

## Interface
- `ADDR_W`, default 7: address width; must match the CPU bus.
- `DATA_W`, default 4: nibble width.
- `DEPTH`, default 128: number of entries; equals 2**ADDR_W.
- `clk`  in  1: single clock, shared with the CPU.
- `rst_n`  in  1: **Reset is synchronous and active-low.**
- `bus_in`  in  8: CPU bus output; [6:0] address or store data in [3:0], [7] write-cycle flag `wcyc`.
- `data_out`  out  4: nibble to the CPU data input.
- `cpu_rst`  out  1: active-high reset to the CPU.
- `prog_en`  in  1: host programming mode request.
- `prog_valid`  in  1: host nibble valid.
- `prog_data`  in  4: host nibble.
- `prog_ready`  out  1: block accepts a host nibble this cycle.
- `prog_ptr`  out  7: next host write address.
- `wr_strobe`  out  1: one-cycle pulse when a CPU store commits (debug).

## Operation
- FSM states: `IDLE`, `WDATA`, `PROG`, `RELEASE`.
- IDLE: `data_out = mem[bus_in[6:0]]` combinationally when `wcyc=0`; when `wcyc=1`, latch `waddr <= bus_in[6:0]` and go to WDATA.
- WDATA: `data_out = 0`. If `wcyc=1`, `mem[waddr] <= bus_in[3:0]`, pulse `wr_strobe`, and return to IDLE. If `wcyc=0` (aborted store), discard and return to IDLE.
- A `wcyc=1` in the cycle after a commit starts a new address phase; it is never treated as data.
- `prog_en=1` in any state goes to PROG next cycle and has priority over CPU traffic. An in-flight WDATA is discarded.
- PROG:
  - `prog_ready=1`, `data_out=0`, CPU stores ignored.
  - Each `prog_valid=1` writes `mem[prog_ptr] <= prog_data` and increments `prog_ptr`.
  - `prog_ptr` wraps from DEPTH-1 to 0.
- `prog_en=0` in PROG: go to RELEASE for exactly one cycle, then IDLE. `prog_ptr` clears to 0 on the PROG→RELEASE transition.
- `cpu_rst=1` while `rst_n=0`, in PROG, and in RELEASE; otherwise 0. The CPU therefore starts fetching at address 0 in the first IDLE cycle.
- `prog_ready=0` outside PROG; `prog_valid` is ignored outside PROG.

## Timing
- Read latency is 0 cycles (combinational), sampled by the CPU on the same edge that advances its state.
- A store commits on the clock edge ending the data phase. A read of that address in the next cycle returns the new value.
- A host write commits on the edge where `prog_valid & prog_ready`. The next host write may follow back-to-back.
- Reset (`rst_n=0` at an edge):
  - state ← IDLE, all entries ← 0, `prog_ptr` ← 0.
  - Outputs while in reset: `wr_strobe=0`, `prog_ready=0`, `cpu_rst=1`, `data_out` = 0.
- Reset mid-store discards the data phase. Reset mid-program keeps nothing; memory clears.
- `prog_en` rising while the CPU is in its address phase: no write occurs.

## Structure
- Package `cpu_nibble_mem_pkg` holds the FSM state enum, `ADDR_W`/`DATA_W` defaults, and bus field bit positions (`WCYC_BIT=7`, `ADDR_MSB=6`, `DATA_MSB=3`).
- Sub-module `nibble_mem_array` provides:
  - DEPTH×DATA_W flops, one synchronous write port, one asynchronous read port.
  - Synchronous clear on `rst_n`.
  - Top-level muxes the write address/data between the host and the CPU.

## Test plan
- Reset, then `prog_en=1`, stream nibbles 0x9,0x0,0x3 → `mem[0..2]=9,0,3`, `prog_ptr=3`, `cpu_rst=1`. Drop `prog_en` → `cpu_rst` stays high one more cycle; `prog_ptr=0`.
- IDLE, `bus_in=0x05` → `data_out=mem[5]` in the same cycle; `bus_in=0x7F` → `mem[127]`.
- Store sequence `bus_in=0xAA` (wcyc, addr 0x2A) then `bus_in=0x87` → `wr_strobe` pulses; `mem[0x2A]=7`. Next-cycle read of 0x2A returns 7.
- Aborted store: `bus_in=0x90` then `0x10` → no write; `mem[0x10]` unchanged; state IDLE.
- Host streams 130 nibbles → `prog_ptr` wraps; entries 0 and 1 hold nibbles 128 and 129.
- `rst_n=0` between address and data phases → no commit, all entries read 0, `cpu_rst=1`.
